// File: rtl/dmem_responder_pkg.sv
// ============================================================================
//  Module   : dmem_responder_pkg
//  Brief    : Shared state encodings, defaults and error check for dmem_responder
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_wait = 2'b01;
    localparam logic [1:0] c_st_ack  = 2'b10;

    localparam int c_default_latency = 4;
    localparam int c_word_w          = 32;
    localparam int c_align_bits      = 2;
    localparam int c_cnt_w           = 4;

    // Misaligned, or any address bit above the implemented word range is set.
    function automatic logic addr_err(input logic [c_word_w-1:0] addr, input int depth_w);
        return (addr[c_align_bits-1:0] != '0) || ((addr >> (depth_w + c_align_bits)) != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  Module   : dmem_array
//  Brief    : Synchronous single-port 2^DEPTH_W x 32 word RAM, registered read
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int DEPTH_W = 10
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] r_mem [2**DEPTH_W];
    logic [31:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
        r_rdata <= r_mem[addr_i];
    end

    assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Fixed-latency data-memory responder (req/ack) in front of a word RAM
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_W = 10,
    parameter int LATENCY = c_default_latency
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [31:0]        r_rdata_hold;

    logic               w_idle;
    logic               w_ack;
    logic               w_acc_we;
    logic [31:0]        w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic               w_acc_err;
    logic               w_to_ack;
    logic               w_ram_we;
    logic [31:0]        w_ram_rdata;
    logic [31:0]        w_ack_rdata;

    assign w_idle = (r_state == c_st_idle);
    assign w_ack  = (r_state == c_st_ack);

    // With LATENCY=1 the RAM is accessed on the acceptance edge itself, so the
    // access fields come straight from the inputs while idle.
    assign w_acc_we    = w_idle ? we_i    : r_we;
    assign w_acc_addr  = w_idle ? addr_i  : r_addr;
    assign w_acc_wdata = w_idle ? wdata_i : r_wdata;
    assign w_acc_err   = addr_err(w_acc_addr, DEPTH_W);

    assign w_to_ack = (w_idle && req_i && (LATENCY == 1)) ||
                      ((r_state == c_st_wait) && (r_cnt == '0));
    assign w_ram_we = w_to_ack && w_acc_we && !w_acc_err;

    dmem_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_ram_we),
        .addr_i  (w_acc_addr[DEPTH_W+1:2]),
        .wdata_i (w_acc_wdata),
        .rdata_o (w_ram_rdata)
    );

    // RAM read data is live only in ACK; afterwards the held copy is shown.
    assign w_ack_rdata = (r_we || r_err) ? 32'd0 : w_ram_rdata;
    assign rdata_o     = w_ack ? w_ack_rdata : r_rdata_hold;
    assign err_o       = r_err;
    assign ack_o       = w_ack;
    assign busy_o      = (r_state == c_st_wait) || w_ack;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if (w_to_ack) begin
                r_err <= w_acc_err;
            end
            if (w_ack) begin
                r_rdata_hold <= w_ack_rdata;
            end
            case (r_state)
                c_st_idle: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        if (LATENCY == 1) begin
                            r_state <= c_st_ack;
                        end else begin
                            r_cnt   <= c_cnt_w'(LATENCY - 2);
                            r_state <= c_st_wait;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_ack;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_ack: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Scoreboard bench for dmem_responder at LATENCY=4 and LATENCY=1
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;

    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ack1, err1, busy1;
    logic [31:0] addr1, wdata1, rdata1;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    int          n_chk;
    int          n_err;
    bit          busy_count_en;
    int          busy_cnt;

    dmem_responder #(.DEPTH_W(10), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .busy_o(busy0)
    );

    dmem_responder #(.DEPTH_W(10), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops the oldest expectation of its DUT.
    always @(negedge clk) begin
        if (busy_count_en && busy0) busy_cnt++;
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("d4_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("d4_ack_cycle", cyc, e0.cyc);
                chk("d4_rdata", rdata0, e0.rdata);
                chk("d4_err", {31'd0, err0}, {31'd0, e0.err});
            end
        end
        if (ack1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("d1_ack_cycle", cyc, e1.cyc);
                chk("d1_rdata", rdata1, e1.rdata);
                chk("d1_err", {31'd0, err1}, {31'd0, e1.err});
            end
        end
    end

    task automatic set_req(input int sel, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Called in an idle cycle (#1 after a posedge); returns in the idle cycle after ack.
    task automatic issue(input int sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit perturb);
        exp_t e;
        int   lat;
        lat = (sel == 0) ? 4 : 1;
        set_req(sel, 1'b1, w, a, d);
        @(posedge clk); #1;
        e.cyc   = cyc + lat - 1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        if (perturb) set_req(sel, 1'b1, ~w, a ^ 32'h4, 32'hFFFF_FFFF);
        repeat (lat - 1) @(posedge clk);
        #1;
        if (sel == 0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t e;
        n_chk = 0;
        n_err = 0;
        busy_count_en = 1'b0;
        busy_cnt = 0;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ack0}, 32'd0);
        chk("reset_rdata", rdata0, 32'd0);
        chk("reset_err", {31'd0, err0}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LATENCY=4: store then load, misaligned store, out-of-range load.
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("hold_rdata", rdata0, 32'hDEAD_BEEF);
        chk("hold_ack_low", {31'd0, ack0}, 32'd0);
        issue(0, 1'b1, 32'h12, 32'hAAAA_AAAA, 32'd0, 1'b1, 1'b0);
        chk("hold_err", {31'd0, err0}, 32'd1);
        issue(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        busy_cnt = 0;
        busy_count_en = 1'b1;
        issue(0, 1'b0, 32'h0000_1000, 32'd0, 32'd0, 1'b1, 1'b0);
        busy_count_en = 1'b0;
        chk("busy_cycles", busy_cnt, 32'd4);

        // Input perturbation during WAIT.
        issue(0, 1'b1, 32'h34, 32'h1357_9BDF, 32'd0, 1'b0, 1'b0);
        issue(0, 1'b1, 32'h30, 32'h0BAD_CAFE, 32'd0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h30, 32'd0, 32'h0BAD_CAFE, 1'b0, 1'b0);
        issue(0, 1'b0, 32'h34, 32'd0, 32'h1357_9BDF, 1'b0, 1'b0);

        // LATENCY=1: preload, then back-to-back loads with req held high.
        issue(1, 1'b1, 32'h0, 32'h1111_1111, 32'd0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h4, 32'h2222_2222, 32'd0, 1'b0, 1'b0);
        set_req(1, 1'b1, 1'b0, 32'h0, 32'd0);
        @(posedge clk); #1;
        e.cyc = cyc; e.rdata = 32'h1111_1111; e.err = 1'b0;
        q1.push_back(e);
        addr1 = 32'h4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e.cyc = cyc; e.rdata = 32'h2222_2222; e.err = 1'b0;
        q1.push_back(e);
        req1 = 1'b0;
        @(posedge clk); #1;

        // Reset during WAIT aborts a store.
        issue(0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
        issue(0, 1'b0, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("abort_ack", {31'd0, ack0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_rdata", rdata0, 32'd0);
        chk("abort_err", {31'd0, err0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        chk("d4_all_acked", q0.size(), 32'd0);
        chk("d1_all_acked", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
